// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, coordinates, strobes and a
// prefetch request running PREFETCH pixels ahead. Optional colour bars: VGA_TIMING_TESTPAT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned PREFETCH = 2
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             run,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             sof,
  output logic             eol,
  output logic             req,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
`ifdef VGA_TIMING_TESTPAT_EN
  output logic             busy,
  output logic [23:0]      tp_rgb
`else
  output logic             busy
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HMax    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMax    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HAct    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VAct    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] XaInit  = CNT_W'(PREFETCH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, xa_q, xa_d, ya_q, ya_d;
  logic             frame_end, active, vis, vis_a;

  logic             hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;
  logic             sof_q, sof_d, eol_q, eol_d, req_q, req_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, req_x_q, req_x_d, req_y_q, req_y_d;

  assign frame_end = (x_q == HMax) && (y_q == VMax);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (run) state_d = StRun;
      StRun:   if (!run) state_d = StDrain;
      StDrain: begin
        if (run)            state_d = StRun;
        else if (frame_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lookahead pair wraps exactly like the display pair, PREFETCH positions ahead.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    xa_d = xa_q;
    ya_d = ya_q;
    if (state_q == StIdle || state_d == StIdle) begin
      x_d  = '0;
      y_d  = '0;
      xa_d = XaInit;
      ya_d = '0;
    end else begin
      if (x_q == HMax) begin
        x_d = '0;
        y_d = (y_q == VMax) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (xa_q == HMax) begin
        xa_d = '0;
        ya_d = (ya_q == VMax) ? '0 : ya_q + 1'b1;
      end else begin
        xa_d = xa_q + 1'b1;
      end
    end
  end

  always_comb begin
    active  = (state_q != StIdle);
    vis     = active && (x_q < HAct) && (y_q < VAct);
    vis_a   = active && (xa_q < HAct) && (ya_q < VAct);
    hsync_d = (active && x_q >= HsStart && x_q < HsEnd) ? HS_POL : ~HS_POL;
    vsync_d = (active && y_q >= VsStart && y_q < VsEnd) ? VS_POL : ~VS_POL;
    valid_d = vis;
    h_cnt_d = vis ? x_q : '0;
    v_cnt_d = vis ? y_q : '0;
    sof_d   = vis && (x_q == '0) && (y_q == '0);
    eol_d   = vis && (x_q == HLast);
    req_d   = vis_a;
    req_x_d = vis_a ? xa_q : '0;
    req_y_d = vis_a ? ya_q : '0;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      xa_q    <= XaInit;
      ya_q    <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      valid_q <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      req_q   <= 1'b0;
      req_x_q <= '0;
      req_y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      req_q   <= req_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign valid = valid_q;
  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;
  assign sof   = sof_q;
  assign eol   = eol_q;
  assign req   = req_q;
  assign req_x = req_x_q;
  assign req_y = req_y_q;
  assign busy  = (state_q != StIdle);

`ifdef VGA_TIMING_TESTPAT_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_q >= CNT_W'(i * BAR_W)) bar = 3'(i);
    end
    case (bar)
      3'd0:    rgb_d = 24'hFFFFFF;
      3'd1:    rgb_d = 24'hFFFF00;
      3'd2:    rgb_d = 24'h00FFFF;
      3'd3:    rgb_d = 24'h00FF00;
      3'd4:    rgb_d = 24'hFF00FF;
      3'd5:    rgb_d = 24'hFF0000;
      3'd6:    rgb_d = 24'h0000FF;
      default: rgb_d = 24'h000000;
    endcase
    if (!vis) rgb_d = 24'h000000;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign tp_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 24x10 raster (16x6 active), PREFETCH=4,
// plus a second instance with active-high syncs and PREFETCH=0.
module tb_vga_timing_gen;

  localparam int HT = 24;
  localparam int VT = 10;
  localparam int FT = HT * VT;

  logic        pclk = 1'b0;
  logic        reset;
  logic        run;
  logic        hsync, vsync, valid, sof, eol, req, busy;
  logic [11:0] h_cnt, v_cnt, req_x, req_y;
  logic        b_hsync, b_vsync, b_valid, b_sof, b_eol, b_req, b_busy;
  logic [11:0] b_h_cnt, b_v_cnt, b_req_x, b_req_y;
`ifdef VGA_TIMING_TESTPAT_EN
  logic [23:0] tp_rgb, b_tp_rgb;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .PREFETCH(4)
  ) u_dut (
    .pclk(pclk), .reset(reset), .run(run),
    .hsync(hsync), .vsync(vsync), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .sof(sof), .eol(eol), .req(req), .req_x(req_x), .req_y(req_y),
`ifdef VGA_TIMING_TESTPAT_EN
    .busy(busy), .tp_rgb(tp_rgb)
`else
    .busy(busy)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .PREFETCH(0)
  ) u_dut_pol (
    .pclk(pclk), .reset(reset), .run(run),
    .hsync(b_hsync), .vsync(b_vsync), .valid(b_valid), .h_cnt(b_h_cnt), .v_cnt(b_v_cnt),
    .sof(b_sof), .eol(b_eol), .req(b_req), .req_x(b_req_x), .req_y(b_req_y),
`ifdef VGA_TIMING_TESTPAT_EN
    .busy(b_busy), .tp_rgb(b_tp_rgb)
`else
    .busy(b_busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_hcnt"}, 32'(h_cnt), 0);
    chk({tag, "_vcnt"}, 32'(v_cnt), 0);
    chk({tag, "_sof"}, 32'(sof), 0);
    chk({tag, "_eol"}, 32'(eol), 0);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_reqxy"}, {8'd0, req_x, req_y}, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_b_hsync"}, 32'(b_hsync), 0);
    chk({tag, "_b_vsync"}, 32'(b_vsync), 0);
    chk({tag, "_b_busy"}, 32'(b_busy), 0);
  endtask

  // Expected outputs for the t-th cycle after the first valid of a run.
  task automatic check_pos(input int t, input bit exp_busy);
    int p, x, y, pa, xa, ya;
    bit vis, vis_a, hs, vs;
    p     = t % FT;
    x     = p % HT;
    y     = p / HT;
    pa    = (t + 4) % FT;
    xa    = pa % HT;
    ya    = pa / HT;
    vis   = (x < 16) && (y < 6);
    vis_a = (xa < 16) && (ya < 6);
    hs    = (x >= 18) && (x < 21);
    vs    = (y >= 7) && (y < 9);
    chk("valid", 32'(valid), 32'(vis));
    chk("hcnt", 32'(h_cnt), vis ? x : 0);
    chk("vcnt", 32'(v_cnt), vis ? y : 0);
    chk("hsync", 32'(hsync), 32'(!hs));
    chk("vsync", 32'(vsync), 32'(!vs));
    chk("sof", 32'(sof), 32'(vis && x == 0 && y == 0));
    chk("eol", 32'(eol), 32'(vis && x == 15));
    chk("req", 32'(req), 32'(vis_a));
    chk("req_x", 32'(req_x), vis_a ? xa : 0);
    chk("req_y", 32'(req_y), vis_a ? ya : 0);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("b_hsync", 32'(b_hsync), 32'(hs));
    chk("b_vsync", 32'(b_vsync), 32'(vs));
    chk("b_req", 32'(b_req), 32'(vis));
    chk("b_reqxy", {8'd0, b_req_x, b_req_y}, vis ? {8'd0, 12'(x), 12'(y)} : 0);
`ifdef VGA_TIMING_TESTPAT_EN
    chk("tp_rgb", 32'(tp_rgb), vis ? 32'(bars[x / 2]) : 0);
`endif
  endtask

  // run must already be high; returns at the negedge where the first valid is visible.
  task automatic start_frame(input string tag);
    @(posedge pclk);
    @(negedge pclk);
    chk({tag, "_lat1_valid"}, 32'(valid), 0);
    chk({tag, "_lat1_busy"}, 32'(busy), 1);
    @(posedge pclk);
    @(negedge pclk);
    chk({tag, "_first_sof"}, 32'(sof), 1);
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge pclk);
    check_idle("rst");
    reset = 1'b1;
    @(negedge pclk);
    check_idle("idle");

    run = 1'b1;
    start_frame("start");
    // Frames 0-3: run dropped and restored inside frame 2, dropped for good in frame 3.
    for (int t = 0; t < 4 * FT; t++) begin
      if (t == 2 * FT + 2 * HT) run = 1'b0;
      if (t == 2 * FT + 5 * HT) run = 1'b1;
      if (t == 3 * FT + 3 * HT) run = 1'b0;
      check_pos(t, t != 4 * FT - 1);
      if (t == 18) chk("hs_first_low", 32'(hsync), 0);
      if (t == 21) chk("hs_after_window", 32'(hsync), 1);
      if (t == 7 * HT) chk("vs_line7", 32'(vsync), 0);
      if (t == FT - 4) chk("req00_prev_frame", {7'd0, req, req_x, req_y}, {7'd0, 1'b1, 24'd0});
      if (t == FT) chk("sof_period", 32'(sof), 1);
      @(negedge pclk);
    end
    for (int i = 0; i < 5; i++) begin
      check_idle("drained");
      @(negedge pclk);
    end

    run = 1'b1;
    start_frame("restart");
    for (int t = 0; t <= 3 * HT + 12; t++) begin
      check_pos(t, 1'b1);
      if (t < 3 * HT + 12) @(negedge pclk);
    end
    chk("pre_reset_pos", {8'd0, h_cnt, v_cnt}, {8'd0, 12'd12, 12'd3});
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge pclk);
    reset = 1'b1;
    start_frame("post_rst");
    for (int t = 0; t < FT; t++) begin
      check_pos(t, 1'b1);
      @(negedge pclk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 timing block.
- Produces hsync, vsync, a data-enable and active-pixel coordinates for the video output path.
- Adds programmable sync polarity, frame/line strobes, run/stop control with clean frame-boundary stop, and a prefetch request that runs PREFETCH pixels ahead of display, for frame-buffer/line-buffer readers (e.g. the edge-detector output buffer).
- Sits between the pixel-clock domain root and the pixel source/DAC interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pclk)
- H_SYNC, 96, hsync pulse width (pclk)
- H_BP, 48, horizontal back porch (pclk)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CNT_W, 12, width of all counters and coordinate outputs
- PREFETCH, 2, request lead in pclk cycles; legal range 0 to H_FP+H_SYNC+H_BP

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- run  in  1  level; 1 = generate timing, 0 = stop at the next frame end
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- valid  out  1  active-video data enable
- h_cnt  out  CNT_W  active x, 0..H_ACTIVE-1; 0 when valid=0
- v_cnt  out  CNT_W  active y, 0..V_ACTIVE-1; 0 when valid=0
- sof  out  1  one-cycle pulse at the first active pixel of a frame
- eol  out  1  one-cycle pulse at the last active pixel of each line
- req  out  1  pixel fetch request, PREFETCH cycles ahead of valid
- req_x  out  CNT_W  x of requested pixel
- req_y  out  CNT_W  y of requested pixel
- busy  out  1  1 while the FSM is not IDLE

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Position counters x (0..H_TOTAL-1) and y (0..V_TOTAL-1); order within a line and a frame is active, front porch, sync, back porch.
- x wraps to 0 after H_TOTAL-1 and increments y. y wraps to 0 when x and y are both at their maxima in the same cycle.
- All outputs are registered: they reflect the position held by the counters in the previous cycle, so latency is 1 pclk from the counter.
- hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 at default); vsync likewise on y (490..491).
- valid = (x < H_ACTIVE) and (y < V_ACTIVE). h_cnt = x and v_cnt = y while valid, else 0.
- sof = valid at x=0,y=0. eol = valid at x=H_ACTIVE-1.
- Lookahead pair (xa, ya) runs exactly PREFETCH positions ahead of (x, y), with the same wrap rules.
- req, req_x and req_y are decoded from (xa, ya) with the same rules as valid, h_cnt and v_cnt. Result: req for pixel (0,0) of frame N+1 occurs PREFETCH cycles before its valid, inside the previous frame's blanking. PREFETCH=0 makes req identical to valid.
- FSM, 3 states:
  - IDLE: counters held at x=0,y=0; lookahead held at position PREFETCH; all sync outputs inactive; valid, req, sof, eol and counts 0; busy=0. Goes to RUN when run=1.
  - RUN: counters advance every pclk. If run=0 is sampled, go to DRAIN.
  - DRAIN: counters keep advancing. If run returns to 1, go back to RUN with no disturbance. At the end of the frame (x=H_TOTAL-1, y=V_TOTAL-1), go to IDLE with counters reloaded as in IDLE.
- Never truncate a frame: a partial frame is never emitted except by reset.
- Leaving IDLE: counting starts at (0,0). First valid/sof appears 2 cycles after run is sampled high (1 cycle FSM, 1 cycle output register).
- Reset (any time, including mid-frame): immediate IDLE, counters and outputs forced to their IDLE values, sync outputs at inactive level (~HS_POL, ~VS_POL).
- Counter widths: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. No modular arithmetic on the outputs beyond the wrap rules above.

Optional Feature:
- Macro VGA_TIMING_TESTPAT_EN.
- Defined: adds output tp_rgb (24 bits), 8 vertical colour bars each H_ACTIVE/8 wide (white, yellow, cyan, green, magenta, red, blue, black), registered and aligned with valid; 0 when valid=0.
- Not defined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Reset low, then run=1 at default parameters -> first sof 2 cycles after run is sampled; sof period 420000 pclk; 640 valid cycles per line; 480 lines per frame.
- Check sync windows -> hsync low for exactly 96 cycles starting 656 cycles after the line's first valid; vsync low for 2 lines (1600 cycles) starting at line 490; both high when HS_POL=VS_POL=1.
- PREFETCH=4 -> req rises 4 cycles before each valid rise, with req_x/req_y equal to the h_cnt/v_cnt seen 4 cycles later; req for (0,0) occurs at x=796,y=524 of the prior frame.
- Drop run at line 100, restore at line 300 -> no gap, continuous frames; drop run and hold it low -> frame completes to line 524, then busy=0 with all outputs idle.
- Assert reset at x=300,y=200 -> next cycle valid=0, hsync=vsync=1 (default polarity), h_cnt=v_cnt=0; release with run=1 -> restart from (0,0) with a full frame.
- With VGA_TIMING_TESTPAT_EN defined -> tp_rgb=FFFFFF at h_cnt 0..79, FFFF00 at 80..159, 000000 at 560..639.
